// File: rtl/vga_plot_sink_if.sv
// Plot-side and framebuffer-side signal bundle for vga_plot_sink.
// The master modport is the environment (drawer muxes plus memory arbiter).
// The slave modport is the sink itself.
interface vga_plot_sink_if #(
  parameter int ADDR_W = 17
);
  logic [8:0]        x;
  logic [7:0]        y;
  logic [2:0]        colour;
  logic              plot;
  logic              mem_grant;
  logic [ADDR_W-1:0] mem_addr;
  logic [2:0]        mem_data;
  logic              mem_wren;

  modport master (
    output x, y, colour, plot, mem_grant,
    input  mem_addr, mem_data, mem_wren
  );

  modport slave (
    input  x, y, colour, plot, mem_grant,
    output mem_addr, mem_data, mem_wren
  );
endinterface

// File: rtl/vga_plot_sink.sv
// vga_plot_sink: consumer end of the drawer plot interface.
// - Range-checks each plotted pixel and converts it to a linear framebuffer address.
// - Buffers accepted pixels in a small FIFO.
// - Drains the FIFO to the framebuffer write port on arbiter grants.
// - A full-screen clear engine sweeps every address with a single colour.
module vga_plot_sink #(
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 240,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 17
) (
  input  logic                        clock,
  input  logic                        reset,
  vga_plot_sink_if.slave              bus,
  input  logic                        clear_req,
  input  logic [2:0]                  clear_colour,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        clear_busy,
  output logic                        overflow,
  output logic [7:0]                  dropped_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + 3;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state_r;
  state_t            next_state_s;
  logic              is_idle_s;
  logic              is_clear_s;

  logic [ENT_W-1:0]  fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic [ENT_W-1:0]  head_s;

  logic [ADDR_W-1:0] clr_addr_r;
  logic [2:0]        clear_colour_r;

  logic              in_range_s;
  logic [ADDR_W-1:0] pix_addr_s;
  logic              start_clear_s;
  logic              push_s;
  logic              push_ok_s;
  logic              pop_s;
  logic              bad_plot_s;
  logic              fifo_full_s;
  logic              clear_write_s;
  logic              clear_last_s;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic: clear_req only matters in IDLE; CLEAR ends on the final address write.
  always_comb begin
    next_state_s = IDLE;
    case (state_r)
      IDLE: begin
        if (clear_req) begin
          next_state_s = CLEAR;
        end else begin
          next_state_s = IDLE;
        end
      end
      CLEAR: begin
        if (clear_last_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = CLEAR;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State decode used by the datapath.
  always_comb begin
    is_idle_s  = 1'b0;
    is_clear_s = 1'b0;
    case (state_r)
      IDLE:    is_idle_s  = 1'b1;
      CLEAR:   is_clear_s = 1'b1;
      default: is_idle_s  = 1'b1;
    endcase
  end

  // Pixel qualification, FIFO handshake and clear-engine strobes.
  // The edge that starts a clear neither pushes nor pops: the clear supersedes pending pixels.
  always_comb begin
    in_range_s    = (ADDR_W'(bus.x) < ADDR_W'(WIDTH)) && (ADDR_W'(bus.y) < ADDR_W'(HEIGHT));
    pix_addr_s    = ADDR_W'(bus.y) * ADDR_W'(WIDTH) + ADDR_W'(bus.x);
    start_clear_s = is_idle_s && clear_req;
    fifo_full_s   = (count_r == DEPTH_C);
    head_s        = fifo_mem_r[rd_ptr_r];
    if (is_idle_s && !clear_req) begin
      push_s     = bus.plot && in_range_s;
      bad_plot_s = bus.plot && !in_range_s;
      pop_s      = (count_r != {CNT_W{1'b0}}) && bus.mem_grant;
    end else begin
      push_s     = 1'b0;
      bad_plot_s = 1'b0;
      pop_s      = 1'b0;
    end
    push_ok_s     = push_s && (!fifo_full_s || pop_s);
    clear_write_s = is_clear_s && bus.mem_grant;
    clear_last_s  = clear_write_s && (clr_addr_r == LAST_ADDR);
  end

  // FIFO storage; contents are only meaningful below count_r, so no reset is needed.
  always_ff @(posedge clock) begin
    if (push_ok_s) begin
      fifo_mem_r[wr_ptr_r] <= {pix_addr_s, bus.colour};
    end
  end

  // FIFO pointers and occupancy; entering CLEAR flushes the queue.
  always_ff @(posedge clock) begin
    if (reset || start_clear_s) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  // Clear engine: address sweep counter and colour latched with the request.
  always_ff @(posedge clock) begin
    if (reset) begin
      clr_addr_r     <= {ADDR_W{1'b0}};
      clear_colour_r <= 3'b000;
    end else if (start_clear_s) begin
      clr_addr_r     <= {ADDR_W{1'b0}};
      clear_colour_r <= clear_colour;
    end else if (clear_write_s) begin
      clr_addr_r     <= clr_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
    end
  end

  // Framebuffer write port: one-cycle strobe per pixel, address/data hold otherwise.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.mem_addr <= {ADDR_W{1'b0}};
      bus.mem_data <= 3'b000;
      bus.mem_wren <= 1'b0;
    end else if (pop_s) begin
      bus.mem_addr <= head_s[ENT_W-1:3];
      bus.mem_data <= head_s[2:0];
      bus.mem_wren <= 1'b1;
    end else if (clear_write_s) begin
      bus.mem_addr <= clr_addr_r;
      bus.mem_data <= clear_colour_r;
      bus.mem_wren <= 1'b1;
    end else begin
      bus.mem_wren <= 1'b0;
    end
  end

  // Status outputs; clear_busy stays high through the cycle carrying the last clear write.
  always_ff @(posedge clock) begin
    if (reset) begin
      clear_busy    <= 1'b0;
      overflow      <= 1'b0;
      dropped_count <= 8'd0;
    end else begin
      clear_busy <= (next_state_s == CLEAR) || is_clear_s;
      if (push_s && fifo_full_s && !pop_s) begin
        overflow <= 1'b1;
      end
      if (bad_plot_s && (dropped_count != 8'hFF)) begin
        dropped_count <= dropped_count + 8'd1;
      end
    end
  end

  assign fifo_count = count_r;

endmodule

// File: tb/tb_vga_plot_sink.sv
// Self-checking bench for vga_plot_sink: stimulus pushes expected writes into a
// scoreboard queue, a negedge monitor pops and compares every mem_wren cycle.
module tb_vga_plot_sink;

  logic       clock;
  logic       reset;
  logic       clear_req;
  logic [2:0] clear_colour;
  logic [3:0] fifo_count;
  logic       clear_busy;
  logic       overflow;
  logic [7:0] dropped_count;

  int checks = 0;
  int errors = 0;

  typedef logic [19:0] exp_t;
  exp_t sb[$];

  vga_plot_sink_if #(.ADDR_W(17)) vif ();

  vga_plot_sink dut (
    .clock         (clock),
    .reset         (reset),
    .bus           (vif),
    .clear_req     (clear_req),
    .clear_colour  (clear_colour),
    .fifo_count    (fifo_count),
    .clear_busy    (clear_busy),
    .overflow      (overflow),
    .dropped_count (dropped_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Scoreboard monitor: every write strobe must match the oldest expected write.
  always @(negedge clock) begin
    exp_t e;
    if (vif.mem_wren) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr %0d data %0d, expected no write",
                 vif.mem_addr, vif.mem_data);
      end else begin
        e = sb.pop_front();
        if ({vif.mem_addr, vif.mem_data} != e) begin
          errors++;
          $display("FAIL write_content: got addr %0d data %0d, expected addr %0d data %0d",
                   vif.mem_addr, vif.mem_data, e[19:3], e[2:0]);
        end
      end
    end
  end

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic expect_write(input int addr, input int data);
    exp_t e;
    e = {17'(addr), 3'(data)};
    sb.push_back(e);
  endtask

  task automatic plot_px(input int px, input int py, input int pc);
    vif.plot   = 1'b1;
    vif.x      = 9'(px);
    vif.y      = 8'(py);
    vif.colour = 3'(pc);
    tick();
    vif.plot   = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int t;
    t = 0;
    while (sb.size() != 0 && t < budget) begin
      tick();
      t++;
    end
    #1;
    check(name, sb.size(), 0);
  endtask

  initial begin
    int exp_cnt;
    int prev_cnt;
    logic g;
    logic done;

    reset        = 1'b1;
    clear_req    = 1'b0;
    clear_colour = 3'd0;
    vif.x        = 9'd0;
    vif.y        = 8'd0;
    vif.colour   = 3'd0;
    vif.plot     = 1'b0;
    vif.mem_grant = 1'b1;
    repeat (3) tick();

    // Reset state
    check("rst_wren", vif.mem_wren, 0);
    check("rst_addr", vif.mem_addr, 0);
    check("rst_count", fifo_count, 0);
    check("rst_busy", clear_busy, 0);
    check("rst_overflow", overflow, 0);
    check("rst_dropped", dropped_count, 0);
    reset = 1'b0;
    tick();

    // Single pixel latency: (100,55) -> 55*320+100 = 17700
    expect_write(17700, 5);
    plot_px(100, 55, 5);
    check("t1_wren_n", vif.mem_wren, 0);
    check("t1_count_n", fifo_count, 1);
    tick();
    check("t1_wren_n1", vif.mem_wren, 1);
    check("t1_addr", vif.mem_addr, 17700);
    check("t1_data", vif.mem_data, 5);
    tick();
    check("t1_wren_off", vif.mem_wren, 0);
    check("t1_addr_hold", vif.mem_addr, 17700);

    // Overflow: 9 plots with no grant, row 1 -> addr 320+i
    vif.mem_grant = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) expect_write(320 + i, i);
      plot_px(i, 1, i);
    end
    check("t2_count_full", fifo_count, 8);
    check("t2_overflow", overflow, 1);
    check("t2_wren_nogrant", vif.mem_wren, 0);
    vif.mem_grant = 1'b1;
    wait_drain("t2_drain", 30);
    repeat (3) tick();
    check("t2_count_empty", fifo_count, 0);

    // Range checks
    expect_write(76799, 3);
    plot_px(320, 0, 1);
    plot_px(0, 240, 2);
    plot_px(319, 239, 3);
    wait_drain("t3_drain", 20);
    check("t3_dropped", dropped_count, 2);

    // Toggling grant over 4 queued pixels
    vif.mem_grant = 1'b0;
    expect_write(3210, 1);
    plot_px(10, 10, 1);
    expect_write(0, 2);
    plot_px(0, 0, 2);
    expect_write(64005, 4);
    plot_px(5, 200, 4);
    expect_write(319, 6);
    plot_px(319, 0, 6);
    check("t5_count4", fifo_count, 4);
    exp_cnt = 4;
    for (int k = 0; k < 10; k++) begin
      g = (k % 2 == 0);
      vif.mem_grant = g;
      prev_cnt = exp_cnt;
      tick();
      if (g && exp_cnt > 0) exp_cnt--;
      check("t5_count", fifo_count, exp_cnt);
      check("t5_wren", vif.mem_wren, (g && prev_cnt > 0) ? 1 : 0);
    end
    check("t5_sb_empty", sb.size(), 0);

    // Full-screen clear; two pending pixels must be flushed, not written
    vif.mem_grant = 1'b0;
    plot_px(1, 1, 1);
    plot_px(2, 2, 2);
    check("t4_pending", fifo_count, 2);
    for (int i = 0; i < 76800; i++) expect_write(i, 7);
    vif.mem_grant = 1'b1;
    clear_colour = 3'd7;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    clear_colour = 3'd0;
    check("t4_busy_start", clear_busy, 1);
    check("t4_flush", fifo_count, 0);
    check("t4_wren_start", vif.mem_wren, 0);
    done = 1'b0;
    for (int t = 0; t < 80000 && !done; t++) begin
      vif.plot  = (sb.size() > 16) ? 1'b1 : 1'b0;
      vif.x     = t[0] ? 9'd400 : 9'd7;
      vif.y     = 8'd3;
      clear_req = (t == 5000);
      tick();
      if (vif.mem_wren && vif.mem_addr == 17'd76799) begin
        check("t4_busy_last", clear_busy, 1);
        done = 1'b1;
      end
    end
    clear_req = 1'b0;
    vif.plot  = 1'b0;
    check("t4_done", done, 1);
    tick();
    check("t4_busy_end", clear_busy, 0);
    check("t4_wren_end", vif.mem_wren, 0);
    wait_drain("t4_drain", 5);
    check("t4_dropped", dropped_count, 2);
    check("t4_count", fifo_count, 0);

    // Saturating drop counter
    vif.plot = 1'b1;
    vif.x = 9'd400;
    vif.y = 8'd10;
    repeat (300) tick();
    vif.plot = 1'b0;
    tick();
    check("t3_saturate", dropped_count, 255);
    check("t3_overflow_sticky", overflow, 1);

    // Reset in the middle of a clear
    for (int i = 0; i < 1000; i++) expect_write(i, 2);
    clear_colour = 3'd2;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    done = 1'b0;
    for (int t = 0; t < 2000 && !done; t++) begin
      tick();
      if (vif.mem_wren && vif.mem_addr == 17'd999) done = 1'b1;
    end
    check("t6_reach_999", done, 1);
    reset = 1'b1;
    tick();
    check("t6_wren", vif.mem_wren, 0);
    check("t6_busy", clear_busy, 0);
    check("t6_count", fifo_count, 0);
    check("t6_overflow", overflow, 0);
    check("t6_dropped", dropped_count, 0);
    tick();
    reset = 1'b0;
    repeat (5) tick();
    check("t6_no_writes", sb.size(), 0);
    check("t6_wren_after", vif.mem_wren, 0);
    check("t6_busy_after", clear_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
